// File: rtl/count_mem_pkg.sv
// Shared types for the count memory arbiter: FSM states,
// host opcodes, grant owner and default widths.
package count_mem_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        CLEAR
    } state_e;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_RDCLR  = 2'b01,
        OP_CLRALL = 2'b10
    } host_op_e;

    typedef enum logic {
        INC  = 1'b0,
        HOST = 1'b1
    } grant_e;

endpackage

// File: rtl/count_mem_arbiter.sv
// Round-robin arbiter that serialises hit increments and host
// readout (read, read-clear, clear-all) onto one count memory.
// Ports:
//   clk, rst                     clock, async active-high reset
//   inc_valid/addr/ready/done    increment requester (RMW +1)
//   host_valid/op/addr/ready     host requester
//   host_rvalid, host_rdata      host read return
//   busy, sat_flag               status (sat_flag is sticky)
//   mem_addr/rd/wr/wdata/rdata   single-port memory, 1-cycle read
module count_mem_arbiter
    import count_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_valid,
    input  logic [ADDR_W-1:0] inc_addr,
    output logic              inc_ready,
    output logic              inc_done,
    input  logic              host_valid,
    input  logic [1:0]        host_op,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              sat_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    grant_e            last_q, last_d;
    grant_e            req_q, req_d;
    host_op_e          op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              sat_q, sat_d;

    logic              idle;
    logic              pick_host;
    host_op_e          op_in;
    logic [DATA_W-1:0] inc_val;

    assign idle = (state_q == IDLE);

    // Host wins when alone, or on a tie when INC was served last.
    assign pick_host = host_valid && (!inc_valid || last_q == INC);

    assign host_ready = idle && pick_host;
    assign inc_ready  = idle && inc_valid && !pick_host;

    // Opcode 11 is folded into a plain read.
    assign op_in = (host_op == 2'b11) ? OP_READ : host_op_e'(host_op);

    assign inc_val = (data_q == '1) ? data_q : data_q + DATA_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= INC;
            req_q    <= INC;
            op_q     <= OP_READ;
            addr_q   <= '0;
            clr_q    <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            req_q    <= req_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            clr_q    <= clr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        req_d    = req_q;
        op_d     = op_q;
        addr_d   = addr_q;
        clr_d    = clr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        sat_d    = sat_q;
        unique case (state_q)
            IDLE: begin
                if (host_ready) begin
                    req_d  = HOST;
                    last_d = HOST;
                    op_d   = op_in;
                    addr_d = host_addr;
                    if (op_in == OP_CLRALL) begin
                        state_d = CLEAR;
                        clr_d   = '0;
                    end else begin
                        state_d = READ;
                    end
                end else if (inc_ready) begin
                    req_d   = INC;
                    last_d  = INC;
                    op_d    = OP_READ;
                    addr_d  = inc_addr;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d = mem_rdata;
                if (req_q == HOST) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                end
                if (req_q == INC || op_q == OP_RDCLR) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (req_q == INC && data_q == '1) begin
                    sat_d = 1'b1;
                end
            end
            CLEAR: begin
                clr_d = clr_q + ADDR_W'(1);
                if (clr_q == '1) begin
                    state_d = IDLE;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        inc_done  = 1'b0;
        unique case (state_q)
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
            end
            WRITE: begin
                mem_wr   = 1'b1;
                mem_addr = addr_q;
                if (req_q == INC) begin
                    inc_done  = 1'b1;
                    mem_wdata = inc_val;
                end
            end
            CLEAR: begin
                mem_wr   = 1'b1;
                mem_addr = clr_q;
            end
            default: begin
            end
        endcase
    end

    assign busy        = !idle;
    assign sat_flag    = sat_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

endmodule

// File: tb/tb_count_mem_arbiter.sv
// Scoreboard bench for count_mem_arbiter: directed scenarios
// plus random traffic against a transaction-level model.
module tb_count_mem_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    typedef struct {
        int          cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit          inc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc_valid = 1'b0;
    logic [AW-1:0] inc_addr = '0;
    logic          inc_ready, inc_done;
    logic          host_valid = 1'b0;
    logic [1:0]    host_op = 2'b00;
    logic [AW-1:0] host_addr = '0;
    logic          host_ready, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          busy, sat_flag;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [DEPTH];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    int  busy_end = -1;
    bit  last_host = 1'b0;
    ev_t exp_rd[$], exp_wr[$], exp_rv[$], exp_sat[$];
    bit  sat_exp = 1'b0;
    logic [DW-1:0] rdata_exp = '0;

    count_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inc_valid(inc_valid), .inc_addr(inc_addr),
        .inc_ready(inc_ready), .inc_done(inc_done),
        .host_valid(host_valid), .host_op(host_op),
        .host_addr(host_addr), .host_ready(host_ready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .busy(busy), .sat_flag(sat_flag),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk(int c, logic [AW-1:0] a,
                               logic [DW-1:0] d, bit inc);
        ev_t e;
        e.cyc = c; e.a = a; e.d = d; e.inc = inc;
        return e;
    endfunction

    // Predictor: decides grants from the round-robin rule and
    // pushes each accepted transaction's expected memory traffic.
    bit  p_bsy, p_gh, p_gi;
    logic [1:0]    p_op;
    logic [DW-1:0] p_v, p_nv;
    always @(negedge clk) begin
        if (poke_en) ref_mem[poke_a] = poke_d;
        if (rst) begin
            busy_end  = -1;
            last_host = 1'b0;
        end else begin
            p_bsy = (cyc <= busy_end);
            p_gh = !p_bsy && host_valid && (!inc_valid || !last_host);
            p_gi = !p_bsy && inc_valid && !p_gh;
            chk("busy", 32'(busy), 32'(p_bsy));
            chk("inc_ready", 32'(inc_ready), 32'(p_gi));
            chk("host_ready", 32'(host_ready), 32'(p_gh));
            if (p_gi) begin
                p_v  = ref_mem[inc_addr];
                p_nv = (p_v == 16'hFFFF) ? p_v : p_v + 16'd1;
                exp_rd.push_back(mk(cyc + 1, inc_addr, '0, 1'b0));
                exp_wr.push_back(mk(cyc + 3, inc_addr, p_nv, 1'b1));
                if (p_v == 16'hFFFF)
                    exp_sat.push_back(mk(cyc + 4, '0, 16'd1, 1'b0));
                ref_mem[inc_addr] = p_nv;
                busy_end  = cyc + 3;
                last_host = 1'b0;
            end else if (p_gh) begin
                p_op = (host_op == 2'b11) ? 2'b00 : host_op;
                if (p_op == 2'b10) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        exp_wr.push_back(mk(cyc + 1 + k, AW'(k), '0, 1'b0));
                        ref_mem[k] = '0;
                    end
                    exp_sat.push_back(mk(cyc + 65, '0, 16'd0, 1'b0));
                    busy_end = cyc + 64;
                end else begin
                    exp_rd.push_back(mk(cyc + 1, host_addr, '0, 1'b0));
                    exp_rv.push_back(mk(cyc + 3, '0, ref_mem[host_addr], 1'b0));
                    busy_end = cyc + 2;
                    if (p_op == 2'b01) begin
                        exp_wr.push_back(mk(cyc + 3, host_addr, '0, 1'b0));
                        ref_mem[host_addr] = '0;
                        busy_end = cyc + 3;
                    end
                end
                last_host = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes.
    ev_t m_e;
    always @(negedge clk) begin
        if (rst) begin
            exp_rd.delete(); exp_wr.delete();
            exp_rv.delete(); exp_sat.delete();
            sat_exp   = 1'b0;
            rdata_exp = '0;
        end else begin
            while (exp_sat.size() > 0 && exp_sat[0].cyc <= cyc) begin
                sat_exp = exp_sat[0].d[0];
                void'(exp_sat.pop_front());
            end
            while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
                chk("rd_missed", 32'(0), 32'(1));
                void'(exp_rd.pop_front());
            end
            while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
                chk("wr_missed", 32'(0), 32'(1));
                void'(exp_wr.pop_front());
            end
            while (exp_rv.size() > 0 && exp_rv[0].cyc < cyc) begin
                chk("rvalid_missed", 32'(0), 32'(1));
                void'(exp_rv.pop_front());
            end
            if (mem_rd && mem_wr) chk("rd_wr_overlap", 32'(1), 32'(0));
            if (mem_rd) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(1), 32'(0));
                end else begin
                    m_e = exp_rd.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(m_e.cyc));
                    chk("rd_addr", 32'(mem_addr), 32'(m_e.a));
                end
            end
            if (mem_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(1), 32'(0));
                end else begin
                    m_e = exp_wr.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(m_e.cyc));
                    chk("wr_addr", 32'(mem_addr), 32'(m_e.a));
                    chk("wr_data", 32'(mem_wdata), 32'(m_e.d));
                    chk("inc_done", 32'(inc_done), 32'(m_e.inc));
                end
            end
            if (!mem_rd && !mem_wr) begin
                chk("idle_addr", 32'(mem_addr), 32'(0));
                chk("idle_wdata", 32'(mem_wdata), 32'(0));
                chk("idle_inc_done", 32'(inc_done), 32'(0));
            end
            if (host_rvalid) begin
                if (exp_rv.size() == 0) begin
                    chk("rvalid_unexpected", 32'(1), 32'(0));
                end else begin
                    m_e = exp_rv.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(m_e.cyc));
                    rdata_exp = m_e.d;
                end
            end
            chk("host_rdata", 32'(host_rdata), 32'(rdata_exp));
            chk("sat_flag", 32'(sat_flag), 32'(sat_exp));
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        poke_en = 1'b1;
        poke_a  = AW'(a);
        poke_d  = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic wait_acc(input bit host);
        int n = 0;
        forever begin
            @(negedge clk);
            if (host ? host_ready : inc_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(1), 32'(0));
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 300) begin
                chk("idle_timeout", 32'(1), 32'(0));
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_inc(input int a);
        inc_valid = 1'b1;
        inc_addr  = AW'(a);
        wait_acc(1'b0);
        inc_valid = 1'b0;
    endtask

    task automatic do_host(input logic [1:0] op, input int a);
        host_valid = 1'b1;
        host_op    = op;
        host_addr  = AW'(a);
        wait_acc(1'b1);
        host_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [DW-1:0] snap [DEPTH];
    int gk[$];
    int gc[$];
    int r;

    initial begin
        for (int i = 0; i < DEPTH; i++)
            poke(i, ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
        @(posedge clk); #1 rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_sat", 32'(sat_flag), 32'(0));
        chk("reset_rdata", 32'(host_rdata), 32'(0));

        poke(5, 16'd7);
        do_inc(5);
        wait_idle();
        chk("inc_mem5", 32'(mem[5]), 32'(8));

        poke(63, 16'h1234);
        do_host(2'b00, 63);
        wait_idle();

        poke(2, 16'd9);
        do_host(2'b01, 2);
        wait_idle();
        chk("rdclr_mem2", 32'(mem[2]), 32'(0));
        do_host(2'b00, 2);
        wait_idle();

        do_reset();
        inc_valid  = 1'b1; inc_addr  = 6'd3;
        host_valid = 1'b1; host_op   = 2'b00; host_addr = 6'd4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_ready) begin gk.push_back(1); gc.push_back(cyc); end
            else if (inc_ready) begin gk.push_back(0); gc.push_back(cyc); end
        end
        @(posedge clk); #1;
        inc_valid = 1'b0; host_valid = 1'b0;
        wait_idle();
        chk("grant_count", 32'(gk.size() >= 4), 32'(1));
        if (gk.size() >= 4) begin
            chk("grant0_host", 32'(gk[0]), 32'(1));
            chk("grant1_inc", 32'(gk[1]), 32'(0));
            chk("grant2_host", 32'(gk[2]), 32'(1));
            chk("grant3_inc", 32'(gk[3]), 32'(0));
            chk("gap_host", 32'(gc[1] - gc[0]), 32'(3));
            chk("gap_inc", 32'(gc[2] - gc[1]), 32'(4));
        end

        poke(1, 16'hFFFF);
        do_inc(1);
        wait_idle();
        chk("sat_set", 32'(sat_flag), 32'(1));
        do_host(2'b10, 0);
        wait_idle();
        chk("sat_cleared", 32'(sat_flag), 32'(0));

        for (int i = 0; i < DEPTH; i++) begin
            snap[i] = 16'($urandom_range(1, 65535));
            poke(i, snap[i]);
        end
        host_valid = 1'b1; host_op = 2'b10;
        wait_acc(1'b1);
        host_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_wr", 32'(mem_wr), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_addr", 32'(mem_addr), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            chk("abort_mem", 32'(mem[k]), (k < 20) ? 32'(0) : 32'(snap[k]));
        for (int k = 20; k < DEPTH; k++)
            poke(k, snap[k]);

        repeat (3000) begin
            inc_valid  = ($urandom_range(0, 2) != 0);
            inc_addr   = AW'($urandom);
            host_valid = ($urandom_range(0, 2) == 0);
            host_addr  = AW'($urandom);
            r = $urandom_range(0, 31);
            host_op = (r == 0) ? 2'b10 : 2'(r % 4 == 2 ? 0 : r % 4);
            @(posedge clk); #1;
        end
        inc_valid = 1'b0; host_valid = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("q_rd_empty", 32'(exp_rd.size()), 32'(0));
        chk("q_wr_empty", 32'(exp_wr.size()), 32'(0));
        chk("q_rv_empty", 32'(exp_rv.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_mem_arbiter.md
Name: count_mem_arbiter

Overview:
- Shares the single-port 64-entry count memory between two requesters:
  - the hit-increment path, which does a read-modify-write +1 per hit;
  - the host readout path, which does read, read-and-clear, or clear-all.
- Serialises every access through a small FSM and arbitrates round-robin when both requesters are pending.
- Sits between the detection/readout sequencing and the count memory.
- Owns the memory control strobes exclusively.

Parameters:
- ADDR_W, 6, memory address width; depth = 2**ADDR_W.
- DATA_W, 16, count word width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inc_valid  in  1  increment request pending.
- inc_addr  in  ADDR_W  bin to increment.
- inc_ready  out  1  increment accepted this cycle (inc_valid && inc_ready).
- inc_done  out  1  one-cycle pulse when the increment write is issued.
- host_valid  in  1  host request pending.
- host_op  in  2  00 read, 01 read-clear, 10 clear-all, 11 treated as 00.
- host_addr  in  ADDR_W  target bin; ignored for clear-all.
- host_ready  out  1  host request accepted this cycle.
- host_rvalid  out  1  one-cycle pulse qualifying host_rdata.
- host_rdata  out  DATA_W  read data; holds its value until the next host_rvalid.
- busy  out  1  high whenever state != IDLE.
- sat_flag  out  1  sticky: an increment hit a bin already at all-ones.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  memory read strobe; data valid on mem_rdata next cycle.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  synchronous read data, 1-cycle latency.

Behaviour:
- Reset values:
  - state IDLE.
  - All strobes, pulses, busy, sat_flag and host_rdata are 0.
  - last_grant = INC, so the first tie goes to HOST.
- Reset mid-operation aborts the operation, including a clear-all in progress. Memory contents are left as-is; no partial write is issued after reset.
- States: IDLE, READ, CAPTURE, WRITE, CLEAR.
- IDLE, arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant the one not in last_grant.
  - ready is combinational: asserted only in IDLE, only for the granted side.
  - On grant, latch op, addr and requester, update last_grant, and go to READ. Clear-all goes to CLEAR instead, with clr_cnt = 0.
- READ: mem_rd = 1, mem_addr = latched addr. Next state is CAPTURE.
- CAPTURE: data_q <= mem_rdata.
  - Increment or read-clear: next state WRITE.
  - Host read: next state IDLE.
  - Any host op: host_rdata <= mem_rdata and host_rvalid registered high for the next cycle.
- WRITE: mem_wr = 1, mem_addr = latched addr. Next state is IDLE.
  - Increment: mem_wdata = data_q + 1, saturating at all-ones. If data_q is all-ones, write all-ones and set sat_flag. inc_done = 1.
  - Read-clear: mem_wdata = 0.
- CLEAR:
  - Each cycle: mem_wr = 1, mem_addr = clr_cnt, mem_wdata = 0, clr_cnt increments.
  - After writing address 2**ADDR_W-1, go to IDLE and clear sat_flag in that same last cycle.
  - Takes 64 cycles; increments stall meanwhile (inc_ready = 0).
- Latency, with acceptance at cycle T:
  - increment: write at T+3, back in IDLE at T+4.
  - host read: host_rvalid at T+3.
  - read-clear: rvalid and write both at T+3.
  - clear-all: writes T+1..T+64.
- No overlap between operations, so back-to-back increments to the same bin never hazard.
- mem_rd and mem_wr are never high together. Outside strobe cycles, mem_addr and mem_wdata are 0.
- A requester may drop valid without being granted; nothing is latched in that case.

Decomposition:
- Package count_mem_pkg holds:
  - the state enum;
  - the host_op codes (OP_READ, OP_RDCLR, OP_CLRALL);
  - default ADDR_W and DATA_W;
  - the grant enum (INC, HOST).
- No sub-module: saturating increment and clear counter stay inline. Single module, about 200 lines.

Test Plan:
- Reset, then inc_valid with inc_addr=5 and mem[5]=7 -> inc_ready at T, mem_rd at T+1, mem_wr with mem_wdata=8 at addr 5 at T+3, inc_done at T+3.
- Host read of addr 0x3F holding 0x1234 -> host_rvalid at T+3 with host_rdata=0x1234, and no mem_wr issued.
- Read-clear of addr 2 holding 9 -> host_rdata=9 at T+3 and mem[2]=0 afterwards; a following read returns 0.
- inc_valid and host_valid held high together from reset -> grants alternate HOST, INC, HOST, INC; each grant is 4 cycles apart (3 for a plain host read).
- Increment bin 1 at 16'hFFFF -> written value 16'hFFFF and sat_flag=1; a later clear-all -> 64 writes of 0, then sat_flag=0 and busy low at T+65.
- Assert rst during CLEAR at clr_cnt=20 -> outputs 0 immediately and state IDLE; mem[20..63] keep their old values.
